// File: rtl/load_store_unit.sv
// load_store_unit: multicycle RV32I/RV64I load/store engine in front of a
// request/acknowledge data memory. Handles B/H/W/D sizes, sign/zero
// extension of loads, read-modify-write for sub-word stores, misalignment
// detection and any number of memory wait states.
module load_store_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            is_store,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [XLEN-1:0] rdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ack
);

   localparam int NBYTES = XLEN / 8;
   localparam int OFFW   = $clog2(NBYTES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_DONE
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic              is_store_q;
   logic [2:0]        funct3_q;
   logic [OFFW-1:0]   off_q;
   logic [XLEN-1:0]   wdata_q;

   logic [OFFW-1:0]   align_mask;
   logic              illegal;
   logic              full_word;

   // Right-aligned byte-lane mask for an access of the given size code.
   function automatic logic [XLEN-1:0] lane_mask(input logic [1:0] size);
      logic [XLEN-1:0] m;
      m = '0;
      case (size)
         2'd0:    m[7:0]  = '1;
         2'd1:    m[15:0] = '1;
         2'd2:    m[31:0] = '1;
         default: m       = '1;
      endcase
      return m;
   endfunction

   // Move the addressed lane down to bit 0 and sign- or zero-extend it.
   function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                   input logic [OFFW-1:0] off,
                                                   input logic [2:0]      f3);
      logic        [XLEN-1:0] lane;
      logic        [XLEN-1:0] zext;
      logic signed [XLEN-1:0] sext;
      lane = word >> {off, 3'b000};
      case (f3[1:0])
         2'd0: begin
            zext = XLEN'(lane[7:0]);
            sext = XLEN'($signed(lane[7:0]));
         end
         2'd1: begin
            zext = XLEN'(lane[15:0]);
            sext = XLEN'($signed(lane[15:0]));
         end
         2'd2: begin
            zext = XLEN'(lane[31:0]);
            sext = XLEN'($signed(lane[31:0]));
         end
         default: begin
            zext = lane;
            sext = lane;
         end
      endcase
      return f3[2] ? zext : sext;
   endfunction

   // Replace the addressed lanes of the read word with the low store bytes.
   function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] word,
                                                   input logic [XLEN-1:0] wd,
                                                   input logic [OFFW-1:0] off,
                                                   input logic [1:0]      size);
      logic [XLEN-1:0] mask;
      mask = lane_mask(size) << {off, 3'b000};
      return (word & ~mask) | ((wd << {off, 3'b000}) & mask);
   endfunction

   // Classify the incoming request: legality and whether it covers a whole word.
   always_comb begin
      align_mask = OFFW'((4'd1 << funct3[1:0]) - 4'd1);
      full_word  = (funct3[1:0] == 2'(OFFW));
      illegal    = (funct3[1:0] > 2'(OFFW))
                || (!is_store && (funct3 == 3'b111))
                || (is_store && funct3[2])
                || ((addr[OFFW-1:0] & align_mask) != '0);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // FSM next state and handshake outputs.
   always_comb begin
      state_d = state_q;
      busy    = 1'b1;
      done    = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (illegal)                    state_d = ST_DONE;
               else if (is_store && full_word) state_d = ST_WR;
               else                            state_d = ST_RD;
            end
         end
         ST_RD: begin
            mem_req = 1'b1;
            if (mem_ack) state_d = is_store_q ? ST_WR : ST_DONE;
         end
         ST_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ack) state_d = ST_DONE;
         end
         default: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Operand capture, memory address/data registers and result registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         is_store_q <= 1'b0;
         funct3_q   <= '0;
         off_q      <= '0;
         wdata_q    <= '0;
         err        <= 1'b0;
         rdata      <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  is_store_q <= is_store;
                  funct3_q   <= funct3;
                  off_q      <= addr[OFFW-1:0];
                  wdata_q    <= wdata;
                  mem_addr   <= {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                  // Full-word stores write wdata as-is; sub-word stores
                  // overwrite this with the merged word before WR.
                  mem_wdata  <= wdata;
                  rdata      <= '0;
                  err        <= illegal;
               end
            end
            ST_RD: begin
               if (mem_ack) begin
                  if (is_store_q)
                     mem_wdata <= store_merge(mem_rdata, wdata_q, off_q, funct3_q[1:0]);
                  else
                     rdata <= load_extend(mem_rdata, off_q, funct3_q);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (XLEN = 64): behavioural byte-array
// reference model, a wait-state memory responder and randomized accesses.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_store;
   logic [2:0]  funct3;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [63:0] rdata;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_ack;

   always #5 clk = ~clk;

   load_store_unit #(.XLEN(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_store  (is_store),
      .funct3    (funct3),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory contents seen by the responder (words) and by the model (bytes).
   logic [63:0] mem [0:15];
   logic [7:0]  ref_bytes [0:127];

   function automatic int widx(input logic [63:0] a);
      return int'((a >> 3) & 64'hF);
   endfunction

   function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a);
      int          n;
      logic [63:0] v;
      n = 1 << f3[1:0];
      v = '0;
      for (int k = 0; k < n; k++)
         v = v | (64'(ref_bytes[int'(a - 64'h100) + k]) << (8 * k));
      if (!f3[2] && n < 8 && v[8 * n - 1])
         v = v | (~64'd0 << (8 * n));
      return v;
   endfunction

   function automatic logic [63:0] model_word(input logic [63:0] a);
      logic [63:0] v;
      int          base;
      base = int'((a & ~64'd7) - 64'h100);
      v = '0;
      for (int k = 0; k < 8; k++) v[8 * k +: 8] = ref_bytes[base + k];
      return v;
   endfunction

   task automatic model_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
      int n;
      n = 1 << f3[1:0];
      for (int k = 0; k < n; k++) ref_bytes[int'(a - 64'h100) + k] = wd[8 * k +: 8];
   endtask

   // Responder/monitor state shared with the stimulus process.
   int          wait_n = 0;
   int          cnt = 0;
   int          rd_cyc = 0;
   int          wr_cyc = 0;
   int          seq_err = 0;
   bit          wr_seen = 0;
   logic [63:0] exp_maddr = '0;
   logic [63:0] exp_wword = '0;
   logic [63:0] last_wword = '0;
   logic [63:0] last_rdata = '0;
   bit          req_prev = 0;
   bit          ack_prev = 0;
   bit          we_prev = 0;
   logic [63:0] addr_prev = '0;
   logic [63:0] wdata_prev = '0;

   // Memory responder: drives ack/rdata on the falling edge, commits writes
   // acknowledged on the preceding rising edge, and checks every request cycle.
   always @(negedge clk) begin
      if (req_prev && ack_prev) begin
         cnt = 0;
         if (we_prev) begin
            mem[widx(addr_prev)] = wdata_prev;
            last_wword = wdata_prev;
         end
      end
      if (mem_req === 1'b1) begin
         mem_ack   = (cnt >= wait_n);
         cnt++;
         mem_rdata = mem[widx(mem_addr)];
         check_eq("mem_addr", mem_addr, exp_maddr);
         if (mem_we) begin
            wr_cyc++;
            wr_seen = 1;
            check_eq("mem_wdata", mem_wdata, exp_wword);
         end else begin
            rd_cyc++;
            if (wr_seen) seq_err++;
         end
      end else begin
         cnt       = 0;
         mem_ack   = 1'($urandom_range(0, 1));
         mem_rdata = {$urandom, $urandom};
      end
      req_prev   = (mem_req === 1'b1);
      ack_prev   = mem_ack;
      we_prev    = mem_we;
      addr_prev  = mem_addr;
      wdata_prev = mem_wdata;
   end

   // One access from start to return to idle, checked against the model.
   task automatic do_access(input bit st, input logic [2:0] f3, input logic [63:0] a,
                            input logic [63:0] wd, input int waits, input bit poke);
      int          n;
      bit          legal;
      logic [63:0] exp_r;
      int          exp_lat;
      int          exp_rd;
      int          exp_wr;
      int          lat;
      bit          got_done;
      n     = 1 << f3[1:0];
      legal = !(!st && f3 == 3'b111) && !(st && f3[2]) && ((a % 64'(n)) == 0);
      exp_r = '0;
      if (legal && !st) exp_r = model_load(f3, a);
      if (legal && st) begin
         model_store(f3, a, wd);
         exp_wword = model_word(a);
      end
      exp_maddr = a & ~64'd7;
      if (!legal)                   exp_lat = 1;
      else if (!st || f3[1:0] == 3) exp_lat = 2 + waits;
      else                          exp_lat = 3 + 2 * waits;
      exp_rd = (legal && (!st || f3[1:0] != 3)) ? 1 + waits : 0;
      exp_wr = (legal && st) ? 1 + waits : 0;
      wait_n  = waits;
      rd_cyc  = 0;
      wr_cyc  = 0;
      seq_err = 0;
      wr_seen = 0;

      @(negedge clk);
      start    = 1'b1;
      is_store = st;
      funct3   = f3;
      addr     = a;
      wdata    = wd;
      @(posedge clk);
      #1 start = 1'b0;
      check_eq("busy_after_accept", 64'(busy), 64'd1);
      lat      = 0;
      got_done = 0;
      while (lat < 60 && !got_done) begin
         @(negedge clk);
         lat++;
         if (poke && lat == 2) begin
            start    = 1'b1;
            is_store = 1'b1;
            funct3   = 3'b011;
            addr     = 64'h108;
            wdata    = {$urandom, $urandom};
         end
         if (poke && lat == 3) start = 1'b0;
         if (done === 1'b1) got_done = 1;
      end
      start = 1'b0;
      check_eq("done_latency", 64'(lat), 64'(exp_lat));
      check_eq("err", 64'(err), 64'(!legal));
      check_eq("rdata", rdata, exp_r);
      last_rdata = rdata;
      @(negedge clk);
      check_eq("done_pulse", 64'(done), 64'd0);
      check_eq("busy_idle", 64'(busy), 64'd0);
      check_eq("rdata_hold", rdata, exp_r);
      check_eq("err_hold", 64'(err), 64'(!legal));
      @(negedge clk);
      check_eq("busy_stays_idle", 64'(busy), 64'd0);
      check_eq("rd_cycles", 64'(rd_cyc), 64'(exp_rd));
      check_eq("wr_cycles", 64'(wr_cyc), 64'(exp_wr));
      check_eq("rd_before_wr", 64'(seq_err), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] w;
      bit          st;
      logic [2:0]  f3;
      logic [63:0] a;
      int          n;

      for (int i = 0; i < 16; i++) begin
         w = (i == 0) ? 64'h8877665544332211 : {$urandom, $urandom};
         mem[i] = w;
         for (int b = 0; b < 8; b++) ref_bytes[8 * i + b] = w[8 * b +: 8];
      end
      rst      = 1'b0;
      start    = 1'b0;
      is_store = 1'b0;
      funct3   = '0;
      addr     = '0;
      wdata    = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_err", 64'(err), 64'd0);
      check_eq("rst_rdata", rdata, 64'd0);
      check_eq("rst_mem_req", 64'(mem_req), 64'd0);
      check_eq("rst_mem_we", 64'(mem_we), 64'd0);
      check_eq("rst_mem_addr", mem_addr, 64'd0);
      check_eq("rst_mem_wdata", mem_wdata, 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Extension cases.
      do_access(0, 3'b000, 64'h107, 64'd0, 0, 0);
      check_eq("lb_107", last_rdata, 64'hFFFFFFFFFFFFFF88);
      do_access(0, 3'b100, 64'h107, 64'd0, 0, 0);
      check_eq("lbu_107", last_rdata, 64'h0000000000000088);
      do_access(0, 3'b001, 64'h102, 64'd0, 0, 0);
      check_eq("lh_102", last_rdata, 64'h0000000000004433);
      do_access(0, 3'b010, 64'h104, 64'd0, 0, 0);
      check_eq("lw_104", last_rdata, 64'hFFFFFFFF88776655);
      do_access(0, 3'b110, 64'h104, 64'd0, 0, 0);
      check_eq("lwu_104", last_rdata, 64'h0000000088776655);

      // Wait states with an ignored start pulse.
      do_access(0, 3'b011, 64'h100, 64'd0, 3, 1);
      check_eq("ld_wait_100", last_rdata, 64'h8877665544332211);

      // Reset in the middle of a read with ack withheld.
      wait_n    = 1000;
      exp_maddr = 64'h108;
      @(negedge clk);
      start    = 1'b1;
      is_store = 1'b0;
      funct3   = 3'b011;
      addr     = 64'h108;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("abort_in_rd", 64'(mem_req), 64'd1);
      rst = 1'b0;
      @(negedge clk);
      check_eq("abort_busy", 64'(busy), 64'd0);
      check_eq("abort_mem_req", 64'(mem_req), 64'd0);
      check_eq("abort_rdata", rdata, 64'd0);
      check_eq("abort_mem_addr", mem_addr, 64'd0);
      rst = 1'b1;
      do_access(0, 3'b000, 64'h100, 64'd0, 0, 0);
      check_eq("lb_100_after_rst", last_rdata, 64'h0000000000000011);

      // Stores.
      do_access(1, 3'b000, 64'h101, 64'hFFAB, 0, 0);
      check_eq("sb_101_word", last_wword, 64'h887766554433AB11);
      do_access(1, 3'b011, 64'h100, 64'h0123456789ABCDEF, 0, 0);
      check_eq("sd_100_word", last_wword, 64'h0123456789ABCDEF);

      // Misalignment and illegal encodings.
      do_access(0, 3'b010, 64'h102, 64'd0, 0, 0);
      do_access(1, 3'b001, 64'h101, 64'h1234, 0, 0);
      do_access(0, 3'b111, 64'h108, 64'd0, 0, 0);
      do_access(1, 3'b100, 64'h108, 64'h55, 0, 0);

      // Randomized mix over the modelled region.
      for (int t = 0; t < 150; t++) begin
         st = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         if (st && $urandom_range(0, 7) != 0) f3[2] = 1'b0;
         n = 1 << f3[1:0];
         a = 64'h100 + 64'($urandom_range(0, 127));
         if ($urandom_range(0, 3) != 0) a = a & ~64'(n - 1);
         do_access(st, f3, a, {$urandom, $urandom}, $urandom_range(0, 3), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
